// File: rtl/dec_nx_scan_pkg.sv
// Shared definitions for the N-to-2^N decoder family: mode encodings and width helpers.
package dec_nx_scan_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A counter always needs at least one bit, even when it only ever holds zero.
    function automatic int div_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/dec_tick_div.sv
// Enabled-cycle divider: emits a one-cycle step pulse every DIV enabled cycles.
module dec_tick_div
    import dec_nx_scan_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam int DW = div_width(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] count_r;
    logic          at_last_s;

    // Terminal-count detect and step pulse; clear takes priority over a step.
    always_comb begin
        at_last_s = (count_r == LAST);
        step      = en && !clr && at_last_s;
    end

    // Divider count: clears on request, otherwise advances only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {DW{1'b0}};
        end else if (clr) begin
            count_r <= {DW{1'b0}};
        end else if (en) begin
            if (at_last_s) begin
                count_r <= {DW{1'b0}};
            end else begin
                count_r <= count_r + DW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/dec_nx_scan.sv
// Registered N-to-2^N decoder with direct one-hot, thermometer and auto-scan modes.
module dec_nx_scan
    import dec_nx_scan_pkg::*;
#(
    parameter int N        = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [N-1:0]        sel,
    output logic [(2**N)-1:0]   y,
    output logic [N-1:0]        idx,
    output logic                valid,
    output logic                wrap
);

    localparam int OUTS = 2 ** N;

    logic [OUTS-1:0] y_r;
    logic [N-1:0]    idx_r;
    logic            valid_r;
    logic            wrap_r;
    mode_e           prev_mode_r;

    mode_e           mode_s;
    logic            entry_s;
    logic            scan_run_s;
    logic            step_s;
    logic [N-1:0]    idx_next_s;

    function automatic logic [OUTS-1:0] onehot(input logic [N-1:0] i);
        logic [OUTS-1:0] r;
        r    = {OUTS{1'b0}};
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [OUTS-1:0] therm(input logic [N-1:0] i);
        logic [OUTS-1:0] r;
        for (int j = 0; j < OUTS; j++) begin
            r[j] = (N'(j) <= i);
        end
        return r;
    endfunction

    // Scan control: entry whenever scan follows any other enabled mode, run otherwise.
    always_comb begin
        mode_s     = mode_e'(mode);
        entry_s    = en && (mode_s == MODE_SCAN) && (prev_mode_r != MODE_SCAN);
        scan_run_s = en && (mode_s == MODE_SCAN) && (prev_mode_r == MODE_SCAN);
        idx_next_s = idx_r + N'(1);
    end

    dec_tick_div #(
        .DIV (SCAN_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (entry_s),
        .en   (scan_run_s),
        .step (step_s)
    );

    // Output registers; en=0 blanks the outputs but keeps idx and prev_mode for resume.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r         <= {OUTS{1'b0}};
            idx_r       <= {N{1'b0}};
            valid_r     <= 1'b0;
            wrap_r      <= 1'b0;
            prev_mode_r <= MODE_DIRECT;
        end else if (!en) begin
            y_r     <= {OUTS{1'b0}};
            valid_r <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            prev_mode_r <= mode_s;
            wrap_r      <= 1'b0;
            case (mode_s)
                MODE_DIRECT: begin
                    y_r     <= onehot(sel);
                    idx_r   <= sel;
                    valid_r <= 1'b1;
                end
                MODE_THERM: begin
                    y_r     <= therm(sel);
                    idx_r   <= sel;
                    valid_r <= 1'b1;
                end
                MODE_SCAN: begin
                    valid_r <= 1'b1;
                    if (entry_s) begin
                        y_r   <= onehot(sel);
                        idx_r <= sel;
                    end else if (step_s) begin
                        y_r    <= onehot(idx_next_s);
                        idx_r  <= idx_next_s;
                        wrap_r <= (idx_r == {N{1'b1}});
                    end else begin
                        // Rebuilt from idx so y reappears correctly after a pause.
                        y_r <= onehot(idx_r);
                    end
                end
                default: begin
                    y_r     <= {OUTS{1'b0}};
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign y     = y_r;
    assign idx   = idx_r;
    assign valid = valid_r;
    assign wrap  = wrap_r;

endmodule

// File: tb/tb_dec_nx_scan.sv
// Scoreboard bench: two decoder instances (N=2/DIV=3 and N=3/DIV=1) against a position-based model.
module tb_dec_nx_scan;

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] idx;
        logic       valid;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] sel = 3'd0;

    logic [3:0] y_a;
    logic [1:0] idx_a;
    logic       valid_a, wrap_a;
    logic [7:0] y_b;
    logic [2:0] idx_b;
    logic       valid_b, wrap_b;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Model state: a scan position is start + (enabled scan cycles since entry) / DIV.
    int         m_idx[2];
    int         m_start[2];
    int         m_k[2];
    logic [1:0] m_prev[2];

    always #5 clk = ~clk;

    dec_nx_scan #(.N(2), .SCAN_DIV(3)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]),
        .y(y_a), .idx(idx_a), .valid(valid_a), .wrap(wrap_a)
    );

    dec_nx_scan #(.N(3), .SCAN_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .y(y_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b)
    );

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input int outs, input int div);
        exp_t e;
        int   s;
        s = int'(sel) % outs;
        e = '0;
        if (rst) begin
            m_idx[i]  = 0;
            m_prev[i] = 2'b00;
        end else if (en) begin
            case (mode)
                2'b00: begin
                    m_idx[i] = s;
                    e.y      = 8'(1 << s);
                    e.valid  = 1'b1;
                end
                2'b01: begin
                    m_idx[i] = s;
                    e.y      = 8'((1 << (s + 1)) - 1);
                    e.valid  = 1'b1;
                end
                2'b10: begin
                    if (m_prev[i] != 2'b10) begin
                        m_start[i] = s;
                        m_k[i]     = 0;
                    end else begin
                        m_k[i]++;
                    end
                    m_idx[i] = (m_start[i] + m_k[i] / div) % outs;
                    e.y      = 8'(1 << m_idx[i]);
                    e.valid  = 1'b1;
                    e.wrap   = (m_k[i] > 0) && (m_k[i] % div == 0) && (m_idx[i] == 0);
                end
                default: begin
                end
            endcase
            m_prev[i] = mode;
        end
        e.idx = 3'(m_idx[i]);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic [2:0] s);
        @(negedge clk);
        rst  = r;
        en   = e;
        mode = m;
        sel  = s;
        model_step(0, 4, 3);
        model_step(1, 8, 1);
    endtask

    // Monitor: one registered result per edge per instance, popped just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp("a_y", int'(y_a), int'(e.y));
            cmp("a_idx", int'(idx_a), int'(e.idx));
            cmp("a_valid", int'(valid_a), int'(e.valid));
            cmp("a_wrap", int'(wrap_a), int'(e.wrap));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("b_y", int'(y_b), int'(e.y));
            cmp("b_idx", int'(idx_b), int'(e.idx));
            cmp("b_valid", int'(valid_b), int'(e.valid));
            cmp("b_wrap", int'(wrap_b), int'(e.wrap));
        end
    end

    initial begin
        logic [1:0] md;
        int         len;
        int         pick;
        int         budget;

        // Reset, then direct decode and thermometer.
        repeat (2) drive(1'b1, 1'b0, 2'b00, 3'd0);
        drive(1'b0, 1'b1, 2'b00, 3'd2);
        drive(1'b0, 1'b1, 2'b01, 3'd0);
        drive(1'b0, 1'b1, 2'b01, 3'd1);
        drive(1'b0, 1'b1, 2'b01, 3'd3);
        drive(1'b0, 1'b1, 2'b01, 3'd7);
        // Scan from 2 for 12 cycles; sel changes mid-scan are ignored.
        drive(1'b0, 1'b1, 2'b10, 3'd2);
        for (int c = 0; c < 11; c++) drive(1'b0, 1'b1, 2'b10, 3'(c));
        // Pause mid-step, then resume.
        drive(1'b0, 1'b1, 2'b00, 3'd0);
        drive(1'b0, 1'b1, 2'b10, 3'd2);
        drive(1'b0, 1'b1, 2'b10, 3'd5);
        repeat (5) drive(1'b0, 1'b0, 2'b10, 3'd6);
        repeat (6) drive(1'b0, 1'b1, 2'b10, 3'd6);
        // Reserved excursion and re-entry with sel=1.
        drive(1'b0, 1'b1, 2'b11, 3'd3);
        drive(1'b0, 1'b1, 2'b10, 3'd1);
        repeat (3) drive(1'b0, 1'b1, 2'b10, 3'd0);
        // Reset mid-scan, then entry at index 0 must not flag a wrap.
        drive(1'b1, 1'b1, 2'b10, 3'd0);
        repeat (14) drive(1'b0, 1'b1, 2'b10, 3'd0);
        // Exhaustive direct and thermometer selects.
        for (int s = 0; s < 8; s++) drive(1'b0, 1'b1, 2'b00, 3'(s));
        for (int s = 0; s < 8; s++) drive(1'b0, 1'b1, 2'b01, 3'(s));
        // Randomized runs of held modes with sparse resets and enable drops.
        for (int blk = 0; blk < 80; blk++) begin
            pick = $urandom_range(0, 5);
            md   = (pick >= 3) ? 2'b10 : ((pick == 2) ? 2'b11 : 2'(pick));
            len  = $urandom_range(1, 20);
            for (int c = 0; c < len; c++) begin
                drive(($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                      md, 3'($urandom));
            end
        end
        // Let the monitor drain the scoreboard within a bounded number of edges.
        budget = 0;
        while ((q0.size() + q1.size() > 0) && budget < 10) begin
            @(posedge clk);
            #2;
            budget++;
        end
        cmp("drain", q0.size() + q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
